// File: rtl/dec_scan_ctrl_pkg.sv
// dec_scan_pkg: shared mode constants and FSM state encoding for the decoder scan sequencer
package dec_scan_pkg;
  localparam logic [1:0] MODE_CONT   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_MAN    = 2'b10;
  typedef enum logic [1:0] {IDLE, DWELL, GAP, HOLD} state_t;
endpackage

// File: rtl/dec_scan_ctrl_if.sv
// dec_scan_ctrl_if: control inputs and decoder-side outputs of the scan sequencer
interface dec_scan_ctrl_if #(parameter int DIV_W = 8);
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [1:0]       man_sel;
  logic [DIV_W-1:0] div;
  logic             blank_gap;
  logic             en;
  logic [1:0]       a;
  logic             busy;
  logic             sweep_done;
  modport master (output start, stop, mode, man_sel, div, blank_gap, input en, a, busy, sweep_done);
  modport slave (input start, stop, mode, man_sel, div, blank_gap, output en, a, busy, sweep_done);
endinterface

// File: rtl/dec_scan_ctrl_dwell_cnt.sv
// dwell_cnt: loadable down-counter timing the dwell of each scan slot
module dwell_cnt #(parameter int DIV_W = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [DIV_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/dec_scan_ctrl.sv
// dec_scan_ctrl: registered en/select sequencer strobing a 2:4 decoder in continuous, single-sweep or manual mode
module dec_scan_ctrl
  import dec_scan_pkg::*;
#(parameter int DIV_W = 8) (
  input logic             clk,
  input logic             rst_n,
  dec_scan_ctrl_if.slave  bus
);
  state_t     state, state_n;
  logic [1:0] mode_q, mode_n, a_n;
  logic       sd_n, ld, dec, zero;
  dwell_cnt #(.DIV_W(DIV_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (bus.div),
    .dec      (dec),
    .zero     (zero)
  );
  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    a_n     = bus.a;
    sd_n    = 1'b0;
    ld      = 1'b0;
    dec     = 1'b0;
    case (state)
      IDLE:
        if (bus.start && !bus.stop && bus.mode != 2'b11) begin
          mode_n  = bus.mode;
          a_n     = bus.mode == MODE_MAN ? bus.man_sel : 2'b00;
          state_n = bus.mode == MODE_MAN ? HOLD : DWELL;
          ld      = bus.mode != MODE_MAN;
        end
      DWELL:
        if (!zero) dec = 1'b1;
        else begin
          sd_n = bus.a == 2'b11;
          if (bus.a == 2'b11 && mode_q == MODE_SINGLE) state_n = IDLE;
          else if (bus.blank_gap) state_n = GAP;
          else begin
            a_n = bus.a + 2'd1;
            ld  = 1'b1;
          end
        end
      GAP: begin
        a_n     = bus.a + 2'd1;
        ld      = 1'b1;
        state_n = DWELL;
      end
      HOLD: a_n = bus.man_sel;
    endcase
    if (bus.stop && state != IDLE) begin
      state_n = IDLE;
      a_n     = bus.a;
      sd_n    = 1'b0;
      ld      = 1'b0;
      dec     = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state          <= IDLE;
      mode_q         <= MODE_CONT;
      bus.a          <= 2'b00;
      bus.en         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.sweep_done <= 1'b0;
    end else begin
      state          <= state_n;
      mode_q         <= mode_n;
      bus.a          <= a_n;
      bus.en         <= state_n == DWELL || state_n == HOLD;
      bus.busy       <= state_n != IDLE;
      bus.sweep_done <= sd_n;
    end
endmodule

// File: tb/tb_dec_scan_ctrl.sv
// tb_dec_scan_ctrl: directed self-checking bench for the decoder scan sequencer
module tb_dec_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  dec_scan_ctrl_if #(.DIV_W(8)) bus ();
  dec_scan_ctrl #(.DIV_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic en, input logic [1:0] a, input logic busy, input logic sd);
    logic [4:0] obs, exp;
    obs = {bus.en, bus.a, bus.busy, bus.sweep_done};
    exp = {en, a, busy, sd};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed en/a/busy/sweep_done=%b required=%b", tag, obs, exp);
    end
  endtask
  initial begin
    bus.start = 0; bus.stop = 0; bus.mode = 0; bus.man_sel = 0; bus.div = 0; bus.blank_gap = 0;
    tick();
    tick();
    chk("reset", 0, 0, 0, 0);
    rst_n = 1;
    bus.mode = 2'b01; bus.div = 2; bus.blank_gap = 0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 12; i++) begin
      chk("single_slot", 1, 2'(i / 3), 1, 0);
      tick();
    end
    chk("single_done", 0, 3, 0, 1);
    tick();
    chk("single_done_clr", 0, 3, 0, 0);
    bus.mode = 2'b00; bus.div = 0; bus.blank_gap = 1; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 16; i++) begin
      chk("cont_gap", (i % 2) == 0, 2'((i / 2) % 4), 1, (i % 8) == 7);
      tick();
    end
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("cont_stop", 0, 0, 0, 0);
    bus.mode = 2'b10; bus.man_sel = 2'b10; bus.start = 1;
    tick();
    bus.start = 0;
    chk("man_first", 1, 2, 1, 0);
    bus.man_sel = 2'b01;
    tick();
    chk("man_track", 1, 1, 1, 0);
    tick();
    chk("man_hold", 1, 1, 1, 0);
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("man_stop", 0, 1, 0, 0);
    tick();
    chk("man_stop_idle", 0, 1, 0, 0);
    bus.mode = 2'b00; bus.div = 5; bus.blank_gap = 0; bus.start = 1;
    tick();
    bus.start = 0;
    chk("abort_slot0", 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("abort_slot1_c3", 1, 1, 1, 0);
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("abort_idle", 0, 1, 0, 0);
    bus.start = 1; bus.stop = 1;
    tick();
    bus.start = 0; bus.stop = 0;
    chk("start_stop", 0, 1, 0, 0);
    bus.mode = 2'b11; bus.start = 1;
    tick();
    bus.start = 0;
    chk("mode_rsvd", 0, 1, 0, 0);
    tick();
    chk("mode_rsvd_idle", 0, 1, 0, 0);
    bus.mode = 2'b00; bus.div = 1; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_slot2", 1, 2, 1, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst_mid", 0, 0, 0, 0);
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("restart_slot0", 1, 0, 1, 0);
    tick();
    tick();
    chk("restart_slot1", 1, 1, 1, 0);
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("restart_stop", 0, 1, 0, 0);
    bus.mode = 2'b00; bus.div = 3; bus.start = 1;
    tick();
    bus.start = 0;
    bus.div = 1;
    chk("div_c1", 1, 0, 1, 0);
    bus.mode = 2'b10; bus.start = 1;
    tick();
    bus.start = 0;
    chk("div_c2", 1, 0, 1, 0);
    tick();
    chk("div_c3", 1, 0, 1, 0);
    tick();
    chk("div_c4", 1, 0, 1, 0);
    tick();
    chk("div_c5", 1, 1, 1, 0);
    tick();
    chk("div_c6", 1, 1, 1, 0);
    tick();
    chk("div_c7", 1, 2, 1, 0);
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("div_stop", 0, 2, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
